// File: rtl/pd_pkg.sv
// Shared constants, state encoding and helpers for the pack distributor and its
// companion aggregator.
package pd_pkg;
  localparam int PD_DATA_W = 8;
  localparam int PD_N_CH   = 8;
  localparam int PD_PACK   = 3;
  localparam int CNT_W     = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    UNPACK = 1'b1
  } state_e;

  function automatic int unsigned next_ch(input int unsigned ptr, input int unsigned n_ch);
    return (ptr + 1 >= n_ch) ? 0 : ptr + 1;
  endfunction

  // Clamp a requested sub-word count to the pack size.
  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] pack);
    return (cnt >= pack) ? pack : cnt;
  endfunction
endpackage

// File: rtl/pd_unpack_buf.sv
// Holds one packed word and walks its sub-words in order; flags the last valid one.
module pd_unpack_buf
  import pd_pkg::*;
#(
  parameter int DATA_W = PD_DATA_W,
  parameter int PACK   = PD_PACK
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [PACK*DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]       load_cnt,
  input  logic                   advance,
  output logic [DATA_W-1:0]      sub_word,
  output logic                   last
);

  logic [PACK*DATA_W-1:0] pack_q, pack_d;
  logic [CNT_W-1:0]       sub_idx_q, sub_idx_d;
  logic [CNT_W-1:0]       cnt_reg_q, cnt_reg_d;

  always_comb begin
    pack_d    = pack_q;
    sub_idx_d = sub_idx_q;
    cnt_reg_d = cnt_reg_q;
    // A load on the same edge as the final delivery replaces the word outright.
    if (load) begin
      pack_d    = load_data;
      sub_idx_d = '0;
      cnt_reg_d = load_cnt;
    end else if (advance) begin
      sub_idx_d = sub_idx_q + CNT_W'(1);
    end
  end

  always_comb begin
    sub_word = '0;
    for (int k = 0; k < PACK; k++) begin
      if (sub_idx_q == CNT_W'(k)) sub_word = pack_q[k*DATA_W +: DATA_W];
    end
    last = (sub_idx_q == cnt_reg_q - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pack_q    <= '0;
      sub_idx_q <= '0;
      cnt_reg_q <= '0;
    end else begin
      pack_q    <= pack_d;
      sub_idx_q <= sub_idx_d;
      cnt_reg_q <= cnt_reg_d;
    end
  end

endmodule

// File: rtl/pack_distributor.sv
// Unpacks packed words and deals sub-words round-robin, in strict channel order,
// to per-channel valid/ready sinks.
module pack_distributor
  import pd_pkg::*;
#(
  parameter int DATA_W = PD_DATA_W,
  parameter int N_CH   = PD_N_CH,
  parameter int PACK   = PD_PACK
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [PACK*DATA_W-1:0]         in_data,
  input  logic [CNT_W-1:0]               in_cnt,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [N_CH-1:0][DATA_W-1:0]    out_data,
  output logic [N_CH-1:0]                out_valid,
  input  logic [N_CH-1:0]                out_ready,
  output logic                           err_cnt0,
  output logic [15:0]                    sent_cnt
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_ptr_q, ch_ptr_d;
  logic              err_cnt0_q, err_cnt0_d;
  logic [15:0]       sent_cnt_q, sent_cnt_d;

  logic              deliver, accept, legal, load;
  logic [DATA_W-1:0] sub_word;
  logic              last;

  pd_unpack_buf #(
    .DATA_W (DATA_W),
    .PACK   (PACK)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (in_data),
    .load_cnt  (sat_cnt(in_cnt, CNT_W'(PACK))),
    .advance   (deliver),
    .sub_word  (sub_word),
    .last      (last)
  );

  always_comb begin
    deliver    = (state_q == UNPACK) & out_ready[ch_ptr_q];
    // Ready on the final delivery lets the next word follow with no bubble.
    in_ready   = (state_q == IDLE) | (deliver & last);
    accept     = in_valid & in_ready;
    legal      = (in_cnt != '0);
    load       = accept & legal;

    state_d    = state_q;
    if (load)                 state_d = UNPACK;
    else if (deliver & last)  state_d = IDLE;

    ch_ptr_d   = deliver ? CH_W'(next_ch(32'(ch_ptr_q), N_CH)) : ch_ptr_q;
    err_cnt0_d = accept & ~legal;
    sent_cnt_d = deliver ? sent_cnt_q + 16'd1 : sent_cnt_q;

    out_valid  = '0;
    out_data   = '0;
    if (state_q == UNPACK) begin
      out_valid[ch_ptr_q] = 1'b1;
      out_data[ch_ptr_q]  = sub_word;
    end
  end

  assign err_cnt0 = err_cnt0_q;
  assign sent_cnt = sent_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ch_ptr_q   <= '0;
      err_cnt0_q <= 1'b0;
      sent_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_ptr_q   <= ch_ptr_d;
      err_cnt0_q <= err_cnt0_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

endmodule

// File: doc/pack_distributor.md
Name: pack_distributor

Overview:
- Reverse-direction companion to the 8-channel packing aggregator.
- Accepts one packed output-side word carrying up to PACK sub-words over a valid/ready handshake.
- Unpacks the sub-words in order and deals them round-robin to N_CH output channels, each with its own valid/ready handshake.
- Used as a loopback stimulus source and as the receive-side splitter in the top wrapper.

Parameters:
- DATA_W, 8, width of one sub-word / one channel data word.
- N_CH, 8, number of output channels.
- PACK, 3, maximum sub-words per packed input word.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_data  input  PACK*DATA_W  packed word; sub-word k = in_data[k*DATA_W +: DATA_W], k=0 delivered first.
- in_cnt  input  2  number of valid sub-words, 1..PACK; 0 is illegal.
- in_valid  input  1  packed word present.
- in_ready  output  1  block can accept a packed word this cycle.
- out_data  output  N_CH x DATA_W  per-channel data; valid only where out_valid is high.
- out_valid  output  N_CH  one-hot or zero; channel currently being served.
- out_ready  input  N_CH  per-channel sink ready.
- err_cnt0  output  1  one-cycle pulse when a word with in_cnt==0 is accepted.
- sent_cnt  output  16  total sub-words delivered since reset; wraps at 2^16.

Behaviour:
- Reset (reset_n low at a clk edge): the following clear to 0: state, buffer, sub_idx, cnt_reg, err_cnt0, sent_cnt, out_valid, out_data. ch_ptr clears to 0. in_ready is 1 in IDLE, so it reads 1 from the first cycle after reset.
- Reset mid-operation: a buffered, partially delivered word is discarded. No out_valid is asserted in the cycle after reset.
- States:
  - IDLE: buffer empty; in_ready=1.
  - UNPACK: buffer holds a word; sub_idx is the next sub-word; cnt_reg holds the latched in_cnt.
- Input accept: in_valid & in_ready at edge N.
  - Latch in_data and in_cnt, set sub_idx=0, go to UNPACK.
  - out_valid[ch_ptr] is high from cycle N+1, giving one cycle latency.
- Illegal count: an accept with in_cnt==0 discards the word, stays or returns to IDLE, and pulses err_cnt0 in cycle N+1. ch_ptr is unchanged.
- In UNPACK, the sub-word is driven on out_data[ch_ptr] and out_valid[ch_ptr]=1. All other out_valid bits are 0 and their out_data bits are 0.
- Delivery occurs when out_ready[ch_ptr] is high at the edge. On delivery:
  - sent_cnt increments.
  - ch_ptr advances, wrapping N_CH-1 -> 0.
  - sub_idx increments.
- Strict order: if the pointed channel is not ready, the block stalls. out_valid and out_data hold stable, and no other channel is served (no skipping).
- Last sub-word: the delivery where sub_idx==cnt_reg-1.
  - in_ready=1 combinationally in that cycle (in_ready = IDLE | (UNPACK & last & out_ready[ch_ptr])). This allows back-to-back words with no bubble.
  - If a new word is accepted in the same edge, stay in UNPACK with the new buffer. Otherwise go to IDLE.
- ch_ptr persists across packed words; it is not reset per word.
- Throughput: at most 1 sub-word per cycle.
- in_cnt values greater than PACK saturate to PACK.
- in_data and in_cnt are only sampled on accept. Input changes while in_ready=0 are ignored.

Decomposition:
- Shared package (pd_pkg): DATA_W/N_CH/PACK defaults, state enum {IDLE, UNPACK}, and function next_ch(ptr) implementing the modulo-N_CH wrap. The aggregator and bench reuse the same constants.
- One natural sub-module: pd_unpack_buf. It holds the buffer, sub_idx and cnt_reg, and outputs the current sub-word and the last flag.
- Top level contains the FSM, ch_ptr, channel demux and counters.

Test Plan:
- Reset then one word in_data=0x332211, in_cnt=3, all out_ready=1 -> ch0=0x11 at cycle 1, ch1=0x22 at cycle 2, ch2=0x33 at cycle 3, sent_cnt=3, in_ready=1 in cycle 3.
- Back-to-back: 30 words, cnt=3, in_valid constant high, all ready -> 90 deliveries in 90 consecutive cycles with no bubble. ch_ptr sequence 0..7 repeated. Channel k receives sub-words k, k+8, … in order. sent_cnt=90.
- Stall: out_ready[1]=0 for 5 cycles while ch1 is pointed -> out_valid[1] and out_data[1] held for 5 cycles, no other out_valid asserted, in_ready=0. Delivery resumes to ch1, then ch2.
- Partial word: in_cnt=1 with 0x0000AA, then in_cnt=2 with 0x00CCBB -> ch0=0xAA, ch1=0xBB, ch2=0xCC. Total 3 deliveries; the upper sub-words of each word are never driven.
- Illegal count: accept in_cnt=0 -> err_cnt0 pulses 1 cycle, no out_valid, ch_ptr and sent_cnt unchanged. The next legal word starts at the same channel.
- Reset mid-word: assert reset_n=0 after 1 of 3 sub-words delivered -> next cycle all outputs 0, in_ready=1, ch_ptr=0. The remaining 2 sub-words are never delivered.
